// File: rtl/sysbus_mem_responder.sv
// Memory-side SYSBUS responder: 64-byte lines as 8x64-bit beats, read data READ_LATENCY cycles after the address ack.
// Read beats are held while respack is low; write beats land on any reqcyc cycle in WDATA and are acked one cycle later.

`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1'b1
`endif
`ifndef SYSBUS_READ
`define SYSBUS_READ 4'h1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 4'h2
`endif

module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = AW - 3;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_LAT,
        S_RESP,
        S_WDATA
    } state_t;

    state_t                    state, state_nxt;
    logic [LW-1:0]             line_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic [2:0]                beat_q;
    logic [CW-1:0]             lat_q;
    logic                      wack_q;
    logic                      mem_we;
    logic                      tag_rd;
    logic                      tag_wr;
    logic [AW-1:0]             word_idx;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Line base is aligned, so base+8*beat is just the beat number in the low index bits.
    assign word_idx = {line_q, beat_q};
    assign tag_rd   = (tag_q[12] == `SYSBUS_MEMORY) && (tag_q[11:8] == `SYSBUS_READ);
    assign tag_wr   = (tag_q[12] == `SYSBUS_MEMORY) && (tag_q[11:8] == `SYSBUS_WRITE);

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus_reqcyc) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (tag_rd) begin
                    if (READ_LATENCY > 1) state_nxt = S_LAT;
                    else                  state_nxt = S_RESP;
                end else if (tag_wr) begin
                    state_nxt = S_WDATA;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LAT: begin
                if (lat_q == LAT_LAST) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus_respack && beat_q == 3'd7) state_nxt = S_IDLE;
            end
            S_WDATA: begin
                if (bus_reqcyc) begin
                    mem_we = !reset;
                    if (beat_q == 3'd7) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
            tag_q  <= '0;
            beat_q <= '0;
            lat_q  <= '0;
            wack_q <= 1'b0;
        end else begin
            wack_q <= mem_we;
            case (state)
                S_IDLE: begin
                    if (bus_reqcyc) begin
                        line_q <= bus_req[AW+2:6];
                        tag_q  <= bus_reqtag;
                    end
                end
                S_ACK: begin
                    beat_q <= '0;
                    lat_q  <= '0;
                end
                S_LAT:   lat_q <= lat_q + 1'b1;
                S_RESP:  if (bus_respack) beat_q <= beat_q + 3'd1;
                S_WDATA: if (bus_reqcyc) beat_q <= beat_q + 3'd1;
                default: ;
            endcase
        end
    end

    // Backing store is deliberately not reset; contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= bus_req;
    end

    assign bus_reqack  = (state == S_ACK) || wack_q;
    assign bus_respcyc = (state == S_RESP);
    assign bus_resp    = bus_respcyc ? mem[word_idx] : '0;
    assign bus_resptag = bus_respcyc ? tag_q : '0;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line writes, reads with stalls, aliasing, bad tags and mid-burst reset.
module tb_sysbus_mem_responder;

    localparam int         RL     = 4;
    localparam int         MW     = 4096;
    localparam logic       TGT    = 1'b1;
    localparam logic [3:0] OP_RD  = 4'h1;
    localparam logic [3:0] OP_WR  = 4'h2;
    localparam logic [63:0] A_BASE = 64'hA000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic        respack;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .MEM_WORDS     (MW),
        .READ_LATENCY  (RL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (reqcyc),
        .bus_req    (req),
        .bus_reqtag (reqtag),
        .bus_reqack (reqack),
        .bus_respcyc(respcyc),
        .bus_respack(respack),
        .bus_resp   (resp),
        .bus_resptag(resptag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_line(input logic [63:0] addr, input logic [63:0] d0, input int gap_after);
        int acks;
        acks   = 0;
        reqcyc = 1'b1;
        req    = addr;
        reqtag = {TGT, OP_WR, 8'h5A};
        tick;
        check("wr_addr_ack", {63'd0, reqack}, 64'd1);
        reqcyc = 1'b0;
        req    = '0;
        tick;
        for (int b = 0; b < 8; b++) begin
            reqcyc = 1'b1;
            req    = d0 + 64'(b);
            tick;
            if (reqack) acks++;
            if (b == gap_after) begin
                reqcyc = 1'b0;
                tick;
                if (reqack) acks++;
            end
        end
        reqcyc = 1'b0;
        req    = '0;
        check("wr_beat_acks", 64'(acks), 64'd8);
        tick;
        check("wr_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic rd_line(input string nm, input logic [63:0] addr, input logic [63:0] d0,
                           input int stall_beat, input int stall_len, input int abort_at);
        int          t;
        int          got;
        int          held;
        int          guard;
        logic [12:0] tg;
        tg     = {TGT, OP_RD, 8'hC3};
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tg;
        tick;
        check({nm, "_ack"}, {63'd0, reqack}, 64'd1);
        reqcyc = 1'b0;
        req    = '0;
        reqtag = '0;
        t      = 1;
        while (!respcyc && t < 40) begin
            tick;
            t++;
        end
        check({nm, "_latency"}, 64'(t), 64'(1 + RL));
        got   = 0;
        held  = 0;
        guard = 0;
        while (got < 8 && guard < 60) begin
            if (got == abort_at) begin
                reset = 1'b1;
                tick;
                reset   = 1'b0;
                respack = 1'b0;
                check({nm, "_rst_respcyc"}, {63'd0, respcyc}, 64'd0);
                check({nm, "_rst_busy"}, {63'd0, busy}, 64'd0);
                check({nm, "_rst_resp"}, resp, 64'd0);
                check({nm, "_rst_tag"}, {51'd0, resptag}, 64'd0);
                tick;
                return;
            end
            check({nm, "_vld"}, {63'd0, respcyc}, 64'd1);
            check({nm, "_dat"}, resp, d0 + 64'(got));
            check({nm, "_tag"}, {51'd0, resptag}, {51'd0, tg});
            if (got == stall_beat && held < stall_len) begin
                respack = 1'b0;
                held++;
            end else begin
                respack = 1'b1;
                got++;
            end
            tick;
            guard++;
        end
        respack = 1'b0;
        check({nm, "_beats"}, 64'(got), 64'd8);
        check({nm, "_end_respcyc"}, {63'd0, respcyc}, 64'd0);
        check({nm, "_end_busy"}, {63'd0, busy}, 64'd0);
        tick;
    endtask

    task automatic bad_req(input string nm, input logic [12:0] tg);
        logic seen;
        seen   = 1'b0;
        reqcyc = 1'b1;
        req    = 64'h40;
        reqtag = tg;
        tick;
        check({nm, "_ack"}, {63'd0, reqack}, 64'd1);
        check({nm, "_busy_ack"}, {63'd0, busy}, 64'd1);
        reqcyc = 1'b0;
        tick;
        check({nm, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({nm, "_single_ack"}, {63'd0, reqack}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (respcyc) seen = 1'b1;
            tick;
        end
        check({nm, "_no_resp"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        reset   = 1'b1;
        reqcyc  = 1'b0;
        req     = '0;
        reqtag  = '0;
        respack = 1'b0;
        tick;
        tick;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_reqack", {63'd0, reqack}, 64'd0);
        check("rst_respcyc", {63'd0, respcyc}, 64'd0);
        check("rst_resp", resp, 64'd0);
        check("rst_resptag", {51'd0, resptag}, 64'd0);

        // Reset and a request in the same cycle: the request must be lost.
        reqcyc = 1'b1;
        req    = 64'h40;
        reqtag = {TGT, OP_RD, 8'h01};
        tick;
        reset  = 1'b0;
        reqcyc = 1'b0;
        check("rst_req_busy", {63'd0, busy}, 64'd0);
        tick;
        check("rst_req_busy2", {63'd0, busy}, 64'd0);
        check("rst_req_noack", {63'd0, reqack}, 64'd0);

        wr_line(64'h40, A_BASE + 64'd8, 8);
        rd_line("rd40", 64'h40, A_BASE + 64'd8, 8, 0, 8);
        rd_line("rd40_stall", 64'h40, A_BASE + 64'd8, 3, 5, 8);

        wr_line(64'h1C0, 64'hD0, 2);
        rd_line("rd1c0", 64'h1C0, 64'hD0, 8, 0, 8);

        rd_line("rd47", 64'h47, A_BASE + 64'd8, 8, 0, 8);
        rd_line("rd_alias", 64'(MW) * 64'd8 + 64'h40, A_BASE + 64'd8, 8, 0, 8);

        bad_req("bad_tgt", {1'b0, OP_WR, 8'h11});
        bad_req("bad_op", {TGT, 4'h7, 8'h22});
        rd_line("rd40_after_bad", 64'h40, A_BASE + 64'd8, 8, 0, 8);

        rd_line("rd40_abort", 64'h40, A_BASE + 64'd8, 8, 0, 4);
        rd_line("rd40_fresh", 64'h40, A_BASE + 64'd8, 1, 2, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
